// File: rtl/julia_frame_scheduler_pkg.sv
// Shared definitions for the Julia frame scheduler: slot and top-level state
// encodings, the round-robin pointer width and a width helper for counters
// and frame-buffer addresses.
package julia_frame_scheduler_pkg;

    // Life cycle of one engine slot.
    typedef enum logic [1:0] {
        SLOT_FREE = 2'd0,
        SLOT_LOAD = 2'd1,
        SLOT_BUSY = 2'd2,
        SLOT_HOLD = 2'd3
    } slot_state_t;

    // Frame-level control states.
    typedef enum logic [1:0] {
        TOP_IDLE = 2'd0,
        TOP_RUN  = 2'd1,
        TOP_DONE = 2'd2
    } top_state_t;

    // Round-robin pointer width; covers up to eight engines with headroom.
    localparam int PTR_W = 4;

    // Bits needed to index 'count' items (at least one). Also gives the
    // smallest legal ADDR_W for a frame: count_bits(H_RES*V_RES).
    function automatic int count_bits(input int count);
        if (count <= 2) begin
            return 1;
        end
        return $clog2(count);
    endfunction

endpackage

// File: rtl/julia_rr_arbiter.sv
// Round-robin arbiter: picks one requester per cycle, starting the search at
// the index after the previous winner. The pointer only moves on a grant.
module julia_rr_arbiter
    import julia_frame_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid
);

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;

    // Wrap an index that may run up to 2*NUM_REQ-2 back into range.
    function automatic int wrap_index(input int value);
        if (value >= NUM_REQ) begin
            return value - NUM_REQ;
        end
        return value;
    endfunction

    // Scan requesters in rotated order from the pointer; first hit wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        ptr_next    = ptr_reg;
        for (int off = 0; off < NUM_REQ; off++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!grant_valid && advance && req[j] &&
                    (j == wrap_index(int'(ptr_reg) + off))) begin
                    grant[j]    = 1'b1;
                    grant_valid = 1'b1;
                    ptr_next    = (j == NUM_REQ - 1) ? '0 : PTR_W'(j + 1);
                end
            end
        end
    end

    // Pointer register: next search starts just past the last winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (grant_valid) begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/julia_frame_scheduler.sv
// Frame scheduler: walks the frame in raster order, hands each pixel's start
// coordinate to a free engine, and funnels engine colours to the frame-buffer
// writer through a single registered valid/ready output.
module julia_frame_scheduler
    import julia_frame_scheduler_pkg::*;
#(
    parameter int                 H_RES   = 320,
    parameter int                 V_RES   = 240,
    parameter int                 NUM_ENG = 4,
    parameter int                 ADDR_W  = 17,
    parameter logic signed [31:0] X_START = 32'sh0,
    parameter logic signed [31:0] Y_START = 32'sh0,
    parameter logic signed [31:0] X_STEP  = 32'sh0,
    parameter logic signed [31:0] Y_STEP  = 32'sh0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [31:0]             cr_in,
    input  logic [31:0]             ci_in,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_ENG-1:0]      eng_enable,
    output logic [32*NUM_ENG-1:0]   eng_x0,
    output logic [32*NUM_ENG-1:0]   eng_y0,
    output logic [31:0]             eng_cr,
    output logic [31:0]             eng_ci,
    input  logic [NUM_ENG-1:0]      eng_calc_end,
    input  logic [16*NUM_ENG-1:0]   eng_color,
    output logic                    wr_valid,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [15:0]             wr_data,
    input  logic                    wr_ready
);

    localparam int                COL_W    = count_bits(H_RES);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(H_RES - 1);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_RES * V_RES - 1);

    top_state_t top_reg;
    top_state_t top_next;

    // Frame walk state.
    logic [31:0]       cr_reg;
    logic [31:0]       ci_reg;
    logic [31:0]       x_reg;
    logic [31:0]       y_reg;
    logic [COL_W-1:0]  col_reg;
    logic [ADDR_W-1:0] pix_reg;
    logic              all_sent_reg;

    // Slot summaries and per-slot pixel tags, flattened for muxing.
    logic [NUM_ENG-1:0]        free_vec;
    logic [NUM_ENG-1:0]        hold_vec;
    logic [NUM_ENG-1:0]        dispatch_vec;
    logic [NUM_ENG-1:0]        grant_vec;
    logic [NUM_ENG*ADDR_W-1:0] tag_flat;
    logic                      dispatch_req;
    logic                      dispatch;
    logic                      grant_valid;
    logic                      out_load;
    logic                      start_accept;
    logic [ADDR_W-1:0]         sel_tag;
    logic [15:0]               sel_color;

    // Output register.
    logic              wr_valid_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [15:0]       wr_data_reg;

    assign start_accept = (top_reg == TOP_IDLE) && start;
    assign dispatch_req = (top_reg == TOP_RUN) && !all_sent_reg;
    assign dispatch     = |dispatch_vec;
    assign out_load     = !wr_valid_reg || wr_ready;

    assign eng_cr   = cr_reg;
    assign eng_ci   = ci_reg;
    assign wr_valid = wr_valid_reg;
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = wr_data_reg;

    // Top-level state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_reg <= TOP_IDLE;
        end else begin
            top_reg <= top_next;
        end
    end

    // Top-level next state: the frame ends only once every pixel has been
    // handed out, every engine is idle and the last result has left.
    always_comb begin
        top_next = top_reg;
        busy     = 1'b1;
        done     = 1'b0;
        case (top_reg)
            TOP_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    top_next = TOP_RUN;
                end
            end
            TOP_RUN: begin
                if (all_sent_reg && (&free_vec) && !wr_valid_reg) begin
                    top_next = TOP_DONE;
                end
            end
            TOP_DONE: begin
                done     = 1'b1;
                top_next = TOP_IDLE;
            end
            default: begin
                busy     = 1'b0;
                top_next = TOP_IDLE;
            end
        endcase
    end

    // Raster walk: latch constants on start, then advance one pixel per
    // dispatch. The last pixel sets a flag instead of wrapping the index, so
    // a frame that exactly fills the address space still terminates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cr_reg       <= '0;
            ci_reg       <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            col_reg      <= '0;
            pix_reg      <= '0;
            all_sent_reg <= 1'b0;
        end else if (start_accept) begin
            cr_reg       <= cr_in;
            ci_reg       <= ci_in;
            x_reg        <= X_START;
            y_reg        <= Y_START;
            col_reg      <= '0;
            pix_reg      <= '0;
            all_sent_reg <= 1'b0;
        end else if (dispatch) begin
            if (pix_reg == LAST_PIX) begin
                all_sent_reg <= 1'b1;
            end else begin
                pix_reg <= pix_reg + 1'b1;
            end
            if (col_reg == LAST_COL) begin
                col_reg <= '0;
                x_reg   <= X_START;
                y_reg   <= y_reg + Y_STEP;
            end else begin
                col_reg <= col_reg + 1'b1;
                x_reg   <= x_reg + X_STEP;
            end
        end
    end

    // Dispatch picks the lowest-numbered free slot, one per cycle.
    always_comb begin
        logic found;
        found        = 1'b0;
        dispatch_vec = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (!found && free_vec[i]) begin
                dispatch_vec[i] = dispatch_req;
                found           = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENG; gi++) begin : g_slot
            slot_state_t       state_reg;
            slot_state_t       state_next;
            logic [31:0]       x0_reg;
            logic [31:0]       y0_reg;
            logic [ADDR_W-1:0] tag_reg;

            assign free_vec[gi]   = (state_reg == SLOT_FREE);
            assign hold_vec[gi]   = (state_reg == SLOT_HOLD);
            assign eng_enable[gi] = (state_reg == SLOT_BUSY) || (state_reg == SLOT_HOLD);
            assign eng_x0[gi*32 +: 32]           = x0_reg;
            assign eng_y0[gi*32 +: 32]           = y0_reg;
            assign tag_flat[gi*ADDR_W +: ADDR_W] = tag_reg;

            // Slot next state: the engine is held enabled until its result
            // has been copied into the output register.
            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    SLOT_FREE: if (dispatch_vec[gi]) state_next = SLOT_LOAD;
                    SLOT_LOAD: state_next = SLOT_BUSY;
                    SLOT_BUSY: if (eng_calc_end[gi]) state_next = SLOT_HOLD;
                    SLOT_HOLD: if (grant_vec[gi]) state_next = SLOT_FREE;
                    default:   state_next = SLOT_FREE;
                endcase
            end

            // Slot state, start coordinate and pixel tag registers.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg <= SLOT_FREE;
                    x0_reg    <= '0;
                    y0_reg    <= '0;
                    tag_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    if (dispatch_vec[gi]) begin
                        x0_reg  <= x_reg;
                        y0_reg  <= y_reg;
                        tag_reg <= pix_reg;
                    end
                end
            end
        end
    endgenerate

    julia_rr_arbiter #(
        .NUM_REQ (NUM_ENG)
    ) u_arbiter (
        .clk         (clk),
        .rst         (rst),
        .req         (hold_vec),
        .advance     (out_load),
        .grant       (grant_vec),
        .grant_valid (grant_valid)
    );

    // Select the granted slot's tag and its engine's colour.
    always_comb begin
        sel_tag   = '0;
        sel_color = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (grant_vec[i]) begin
                sel_tag   = tag_flat[i*ADDR_W +: ADDR_W];
                sel_color = eng_color[i*16 +: 16];
            end
        end
    end

    // Output register: refills when empty or being drained this cycle, and
    // holds steady while the writer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_valid_reg <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
        end else if (out_load) begin
            wr_valid_reg <= grant_valid;
            if (grant_valid) begin
                wr_addr_reg <= sel_tag;
                wr_data_reg <= sel_color;
            end
        end
    end

endmodule

// File: tb/tb_julia_frame_scheduler.sv
// Randomised bench for julia_frame_scheduler on a 4x2 frame with four engines.
// Behavioural engines compute a colour from their start coordinate; every
// write is checked against the colour predicted from its address alone.
module tb_julia_frame_scheduler;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int N  = 4;
    localparam int AW = 3;
    localparam logic signed [31:0] XS    = 32'sd3;
    localparam logic signed [31:0] YS    = -32'sd5;
    localparam logic signed [31:0] XSTEP = 32'sd1;
    localparam logic signed [31:0] YSTEP = 32'sd16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [31:0]     cr_in;
    logic [31:0]     ci_in;
    logic            busy;
    logic            done;
    logic [N-1:0]    eng_enable;
    logic [32*N-1:0] eng_x0;
    logic [32*N-1:0] eng_y0;
    logic [31:0]     eng_cr;
    logic [31:0]     eng_ci;
    logic [N-1:0]    eng_calc_end;
    logic [16*N-1:0] eng_color;
    logic            wr_valid;
    logic [AW-1:0]   wr_addr;
    logic [15:0]     wr_data;
    logic            wr_ready;

    always #5 clk = ~clk;

    julia_frame_scheduler #(
        .H_RES   (H),
        .V_RES   (V),
        .NUM_ENG (N),
        .ADDR_W  (AW),
        .X_START (XS),
        .Y_START (YS),
        .X_STEP  (XSTEP),
        .Y_STEP  (YSTEP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cr_in        (cr_in),
        .ci_in        (ci_in),
        .busy         (busy),
        .done         (done),
        .eng_enable   (eng_enable),
        .eng_x0       (eng_x0),
        .eng_y0       (eng_y0),
        .eng_cr       (eng_cr),
        .eng_ci       (eng_ci),
        .eng_calc_end (eng_calc_end),
        .eng_color    (eng_color),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Frame bookkeeping.
    int          cyc;
    int          lat_mode;
    int          ready_mode;
    int          rel_cyc;
    int          reen_cyc;
    int          wcount;
    int          done_cnt;
    int          done_cyc;
    int          last_acc;
    int          stall_left;
    bit          stall_used;
    bit          seen [H*V];
    logic [31:0] cr_exp;
    logic [31:0] ci_exp;
    logic [AW-1:0] snap_addr;
    logic [15:0]   snap_data;

    // Behavioural engine state.
    int          cnt [N];
    bit          running [N];
    bit          first_seen [N];
    logic [31:0] ex0 [N];
    logic [31:0] ey0 [N];

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Colour an engine produces for a start point under the frame constant.
    function automatic logic [15:0] pix_color(input logic [31:0] x, input logic [31:0] y,
                                              input logic [31:0] cr, input logic [31:0] ci);
        logic [31:0] t;
        t = x * 32'd31 + y * 32'd7;
        return t[15:0] ^ cr[15:0] ^ {ci[7:0], 8'h00};
    endfunction

    function automatic logic [31:0] exp_x(input int a);
        return XS + 32'(a % H) * XSTEP;
    endfunction

    function automatic logic [31:0] exp_y(input int a);
        return YS + 32'(a / H) * YSTEP;
    endfunction

    // Pixel index recovered from a start point (X_STEP=1, Y_STEP=16).
    function automatic int pix_of(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] dx;
        logic [31:0] dy;
        dx = x - XS;
        dy = y - YS;
        return int'(dx) + H * int'(dy >> 4);
    endfunction

    task automatic check_reset_values(input string where);
        check_value({where, "_busy"},     busy, 0);
        check_value({where, "_done"},     done, 0);
        check_value({where, "_enable"},   eng_enable, 0);
        check_value({where, "_x0_zero"},  eng_x0 == '0, 1);
        check_value({where, "_y0_zero"},  eng_y0 == '0, 1);
        check_value({where, "_cr"},       eng_cr, 0);
        check_value({where, "_ci"},       eng_ci, 0);
        check_value({where, "_wr_valid"}, wr_valid, 0);
        check_value({where, "_wr_addr"},  wr_addr, 0);
        check_value({where, "_wr_data"},  wr_data, 0);
    endtask

    // Writer side: choose wr_ready for the coming edge and score any
    // transfer that edge will complete.
    task automatic writer_update();
        int a;
        if (ready_mode == 0) begin
            wr_ready = 1'b1;
        end else if (ready_mode == 1) begin
            wr_ready = ($urandom_range(0, 3) != 0);
        end else begin
            if (!stall_used && cyc >= 6 && wr_valid) begin
                stall_used = 1'b1;
                stall_left = 10;
                snap_addr  = wr_addr;
                snap_data  = wr_data;
            end
            if (stall_left > 0) begin
                if (stall_left < 10) begin
                    check_value("stall_valid", wr_valid, 1);
                    check_value("stall_addr", wr_addr, snap_addr);
                    check_value("stall_data", wr_data, snap_data);
                end
                wr_ready = 1'b0;
                stall_left--;
            end else begin
                wr_ready = 1'b1;
            end
        end
        if (wr_valid && wr_ready) begin
            a = int'(wr_addr);
            $display("write %0d: addr=%0d data=%h cycle=%0d", wcount, a, wr_data, cyc);
            check_value("wr_addr_range", a < H * V, 1);
            if (a < H * V) begin
                check_value("wr_unique", seen[a], 0);
                seen[a] = 1'b1;
                check_value("wr_data", wr_data, pix_color(exp_x(a), exp_y(a), cr_exp, ci_exp));
            end
            if (lat_mode == 2) begin
                check_value("wr_order", a, wcount);
                if (wcount == 0) check_value("first_write_cycle", cyc, rel_cyc + 2);
                if (wcount == 3) check_value("burst_end_cycle", cyc, rel_cyc + 5);
            end
            wcount++;
            last_acc = cyc;
        end
    endtask

    // Behavioural engines: start on enable, finish after a latency, hold
    // the result until enable drops.
    task automatic engine_update();
        bit all_rdy;
        for (int i = 0; i < N; i++) begin
            if (!eng_enable[i]) begin
                running[i]      = 1'b0;
                eng_calc_end[i] = 1'b0;
            end else if (!running[i]) begin
                running[i] = 1'b1;
                ex0[i] = eng_x0[i*32 +: 32];
                ey0[i] = eng_y0[i*32 +: 32];
                if (!first_seen[i]) begin
                    first_seen[i] = 1'b1;
                    check_value($sformatf("first_enable_%0d", i), cyc, 3 + i);
                end else if (i == 0 && rel_cyc >= 0 && reen_cyc < 0) begin
                    reen_cyc = cyc;
                end
                case (lat_mode)
                    0:       cnt[i] = $urandom_range(0, 10);
                    1:       cnt[i] = 3 + pix_of(ex0[i], ey0[i]);
                    default: cnt[i] = 2;
                endcase
            end else if (!eng_calc_end[i] && cnt[i] > 0) begin
                cnt[i]--;
            end
        end
        if (lat_mode != 2) begin
            for (int i = 0; i < N; i++) begin
                if (running[i] && !eng_calc_end[i] && cnt[i] == 0) begin
                    eng_calc_end[i]       = 1'b1;
                    eng_color[i*16 +: 16] = pix_color(ex0[i], ey0[i], eng_cr, eng_ci);
                end
            end
        end else begin
            all_rdy = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (!(running[i] && cnt[i] == 0 && !eng_calc_end[i])) all_rdy = 1'b0;
            end
            if (all_rdy) begin
                for (int i = 0; i < N; i++) begin
                    eng_calc_end[i]       = 1'b1;
                    eng_color[i*16 +: 16] = pix_color(ex0[i], ey0[i], eng_cr, eng_ci);
                end
                if (rel_cyc < 0) rel_cyc = cyc;
            end
        end
    endtask

    task automatic do_abort();
        bit saw;
        rst = 1'b1;
        #1;
        check_reset_values("abort");
        eng_calc_end = '0;
        eng_color    = '0;
        start        = 1'b0;
        for (int i = 0; i < N; i++) running[i] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) saw = 1'b1;
        end
        check_value("abort_quiet", saw, 0);
    endtask

    // One frame: lm = latency mode (0 random, 1 3+pixel, 2 simultaneous),
    // rm = ready mode (0 always, 1 random, 2 ten-cycle stall), poke = cycle
    // of a second start, abort_at = cycle of a mid-frame reset (0 = none).
    task automatic run_frame(input int lm, input int rm, input int poke, input int abort_at);
        bit finished;
        lat_mode   = lm;
        ready_mode = rm;
        rel_cyc    = -1;
        reen_cyc   = -1;
        wcount     = 0;
        done_cnt   = 0;
        done_cyc   = -1;
        last_acc   = -1;
        stall_left = 0;
        stall_used = 1'b0;
        finished   = 1'b0;
        cr_exp     = $urandom;
        ci_exp     = $urandom;
        for (int a = 0; a < H * V; a++) seen[a] = 1'b0;
        for (int i = 0; i < N; i++) begin
            first_seen[i] = 1'b0;
            running[i]    = 1'b0;
        end
        for (cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            if (cyc == 0) check_value("idle_busy", busy, 0);
            if (cyc == 1) check_value("busy_after_start", busy, 1);
            if (cyc == 2) check_value("slot0_load_enable", eng_enable, 0);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                check_value("busy_with_done", busy, 1);
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) check_value("busy_after_done", busy, 0);
            if (done_cyc >= 0 && cyc == done_cyc + 3) finished = 1'b1;
            writer_update();
            engine_update();
            start = (cyc == 0) || (poke > 0 && cyc == poke);
            cr_in = (cyc == 0) ? cr_exp : $urandom;
            ci_in = (cyc == 0) ? ci_exp : $urandom;
            if (abort_at > 0 && cyc == abort_at) begin
                do_abort();
                return;
            end
        end
        check_value("frame_completed", done_cyc >= 0, 1);
        check_value("done_pulses", done_cnt, 1);
        check_value("write_count", wcount, H * V);
        check_value("eng_cr_latched", eng_cr, cr_exp);
        check_value("eng_ci_latched", eng_ci, ci_exp);
        if (done_cyc >= 0) check_value("done_after_last_write", done_cyc, last_acc + 2);
        if (lm == 2) check_value("reenable_cycle", reen_cyc, rel_cyc + 4);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        cr_in        = '0;
        ci_in        = '0;
        eng_calc_end = '0;
        eng_color    = '0;
        wr_ready     = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        run_frame(2, 0, 0, 0);   // simultaneous results, pointer from 0
        run_frame(1, 0, 0, 0);   // latency 3 + pixel index
        run_frame(0, 1, 0, 0);   // random latency and ready
        run_frame(0, 2, 0, 0);   // writer stall mid-frame
        run_frame(1, 1, 5, 0);   // start again while busy
        run_frame(0, 1, 0, 7);   // reset mid-frame
        run_frame(2, 0, 0, 0);   // full frame after reset
        repeat (4) run_frame(0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
